// File: rtl/sd_clk_gen_if.sv
// ---------------------------------------------------------------------------
// sd_clk_gen_if
// Groups the control and status signals between the host clock_control
// logic (master) and the SD clock generator (slave).
//
// Signals:
//   internal_clk_enable_i  master -> slave  internal clock enable
//   sd_clk_enable_i        master -> slave  SD clock enable
//   div_sel_i[9:0]         master -> slave  divisor N (half-period = N cycles, 0 = divide-by-1)
//   pause_i                master -> slave  data-path pause (read buffer full)
//   internal_clk_stable_o  slave -> master  internal clock stable status
//   sd_clk_o               slave -> master  divided SD clock
//   sd_clk_en_p_o          slave -> master  rising-edge strobe
//   sd_clk_en_n_o          slave -> master  falling-edge strobe
//   div_1_o                slave -> master  divide-by-1 mode active
//   sd_clk_running_o       slave -> master  SD clock currently toggling
// ---------------------------------------------------------------------------
interface sd_clk_gen_if;
   logic       internal_clk_enable_i;
   logic       sd_clk_enable_i;
   logic [9:0] div_sel_i;
   logic       pause_i;
   logic       internal_clk_stable_o;
   logic       sd_clk_o;
   logic       sd_clk_en_p_o;
   logic       sd_clk_en_n_o;
   logic       div_1_o;
   logic       sd_clk_running_o;

   // Host-side view: drives enables, divisor and pause; observes status.
   modport master (
      output internal_clk_enable_i, sd_clk_enable_i, div_sel_i, pause_i,
      input  internal_clk_stable_o, sd_clk_o, sd_clk_en_p_o, sd_clk_en_n_o,
             div_1_o, sd_clk_running_o
   );

   // Generator-side view.
   modport slave (
      input  internal_clk_enable_i, sd_clk_enable_i, div_sel_i, pause_i,
      output internal_clk_stable_o, sd_clk_o, sd_clk_en_p_o, sd_clk_en_n_o,
             div_1_o, sd_clk_running_o
   );
endinterface

// File: rtl/sd_clk_gen.sv
// ---------------------------------------------------------------------------
// sd_clk_gen
// SD card clock generator. Divides clk_i by 2*N (N = latched divisor) and
// produces one-cycle strobes marking the rising and falling SD clock edges.
// A pause or disable only ever stops the clock while it is low, and a high
// half-period is always completed (except under reset). N = 0 selects
// divide-by-1 mode, where the pad clock comes from an external gate on clk_i
// and both strobes simply follow the run condition.
//
// Ports:
//   clk_i   in  base controller clock
//   rst_ni  in  synchronous active-low reset
//   bus     sd_clk_gen_if.slave  enables, divisor, pause and status outputs
// ---------------------------------------------------------------------------
module sd_clk_gen (
   input  logic               clk_i,
   input  logic               rst_ni,
   sd_clk_gen_if.slave        bus
);

   typedef enum logic [1:0] {
      OFF  = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } state_t;

   state_t     state;
   logic [9:0] cnt;
   logic [9:0] div_q;
   logic       sd_clk_q;
   logic       en_sync;
   logic       stable_q;

   logic       enables;
   logic       run;
   logic       div_1;
   logic       terminal;

   assign enables  = bus.internal_clk_enable_i & bus.sd_clk_enable_i;
   assign run      = enables & ~bus.pause_i;
   assign div_1    = (div_q == 10'd0);
   // Only meaningful when div_q > 0; divide-by-1 is handled separately.
   assign terminal = (cnt == div_q - 10'd1);

   // Two-stage qualification of the internal clock enable gives the stable
   // flag two cycles after enable rises and drops it one cycle after enable
   // falls, because the second stage is ANDed with the live enable.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         en_sync  <= 1'b0;
         stable_q <= 1'b0;
      end else begin
         en_sync  <= bus.internal_clk_enable_i;
         stable_q <= en_sync & bus.internal_clk_enable_i;
      end
   end

   // Main divider FSM. The divisor is latched only when leaving OFF and at
   // the end of each high half-period, so mid-period divisor changes never
   // alter the half-period in progress. In LOW a dropped run condition
   // restarts the count from zero; HIGH always runs to its terminal count.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= OFF;
         cnt      <= '0;
         div_q    <= '0;
         sd_clk_q <= 1'b0;
      end else begin
         case (state)
            OFF: begin
               cnt      <= '0;
               sd_clk_q <= 1'b0;
               if (run) begin
                  div_q <= bus.div_sel_i;
                  state <= LOW;
               end
            end
            LOW: begin
               if (!run) begin
                  cnt      <= '0;
                  sd_clk_q <= 1'b0;
                  if (!enables) begin
                     state <= OFF;
                  end
               end else if (div_1) begin
                  cnt <= '0;
               end else if (terminal) begin
                  cnt      <= '0;
                  sd_clk_q <= 1'b1;
                  state    <= HIGH;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            HIGH: begin
               if (terminal) begin
                  cnt      <= '0;
                  sd_clk_q <= 1'b0;
                  div_q    <= bus.div_sel_i;
                  state    <= LOW;
               end else begin
                  cnt <= cnt + 10'd1;
               end
            end
            default: begin
               state    <= OFF;
               cnt      <= '0;
               sd_clk_q <= 1'b0;
            end
         endcase
      end
   end

   // Strobes are decoded directly from state, count and run so that a pause
   // kills them in the same cycle, including in divide-by-1 mode. The rising
   // strobe only exists in LOW and the falling one only in HIGH when N > 0,
   // so they can never coincide outside divide-by-1.
   assign bus.sd_clk_en_p_o         = (state == LOW) && run && (div_1 || terminal);
   assign bus.sd_clk_en_n_o         = ((state == LOW) && run && div_1) ||
                                      ((state == HIGH) && terminal);
   assign bus.sd_clk_running_o      = (state == HIGH) || ((state == LOW) && run);
   assign bus.div_1_o               = (state != OFF) && div_1;
   assign bus.sd_clk_o              = sd_clk_q;
   assign bus.internal_clk_stable_o = stable_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// ---------------------------------------------------------------------------
// tb_sd_clk_gen
// Directed testbench for sd_clk_gen. Each cycle's inputs are applied just
// after the rising edge and the outputs are compared a little later in the
// same cycle against hand-computed expected vectors packed as
//   {stable, sd_clk, en_p, en_n, div_1, running}.
// ---------------------------------------------------------------------------
module tb_sd_clk_gen;

   logic clk;
   logic rst_n;

   sd_clk_gen_if bus ();

   sd_clk_gen dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int check_count;
   int pass_count;

   logic [5:0] outs;
   assign outs = {bus.internal_clk_stable_o, bus.sd_clk_o, bus.sd_clk_en_p_o,
                  bus.sd_clk_en_n_o, bus.div_1_o, bus.sd_clk_running_o};

   // Free-running 100 MHz-style base clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to the next cycle, drive its inputs, then let the combinational
   // strobes settle before any sampling.
   task automatic applyStimulus(input logic rst, input logic ie, input logic se,
                                input logic pz, input logic [9:0] div);
      @(posedge clk);
      #1;
      rst_n                     = rst;
      bus.internal_clk_enable_i = ie;
      bus.sd_clk_enable_i       = se;
      bus.pause_i               = pz;
      bus.div_sel_i             = div;
      #2;
   endtask

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [5:0] obs,
                              input logic [5:0] exp);
      check_count++;
      if (obs === exp) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %b expected %b (stable,sd_clk,p,n,div1,running)",
                  tag, obs, exp);
      end
   endtask

   // One running cycle with both enables on, no pause, and its expected vector.
   task automatic runCycle(input string tag, input logic [9:0] div,
                           input logic [5:0] exp);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, div);
      checkOutput(tag, outs, exp);
   endtask

   // A full low half-period of n cycles: running, rising strobe on the last.
   task automatic lowPhase(input string tag, input int n, input logic [9:0] div);
      for (int k = 0; k < n; k++) begin
         runCycle(tag, div, (k == n - 1) ? 6'b101001 : 6'b100001);
      end
   endtask

   // A full high half-period of n cycles: clock high, falling strobe on the last.
   task automatic highPhase(input string tag, input int n, input logic [9:0] div);
      for (int k = 0; k < n; k++) begin
         runCycle(tag, div, (k == n - 1) ? 6'b110101 : 6'b110001);
      end
   endtask

   initial begin
      check_count               = 0;
      pass_count                = 0;
      rst_n                     = 1'b0;
      bus.internal_clk_enable_i = 1'b0;
      bus.sd_clk_enable_i       = 1'b0;
      bus.pause_i               = 1'b0;
      bus.div_sel_i             = 10'd0;

      // Reset: after one reset edge everything reads zero.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("reset", outs, 6'b000000);

      // Internal enable rises with SD enable off: stable on 2nd cycle, no clock.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd4);
      checkOutput("stable_c0", outs, 6'b000000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd4);
      checkOutput("stable_c1", outs, 6'b000000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd4);
      checkOutput("stable_c2", outs, 6'b100000);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd4);
      checkOutput("off_idle", outs, 6'b100000);

      // Divide by 4: OFF cycle, then 4 low / 4 high, twice.
      runCycle("div4_off", 10'd4, 6'b100000);
      for (int i = 0; i < 2; i++) begin
         lowPhase("div4_low", 4, 10'd4);
         highPhase("div4_high", 4, 10'd4);
      end

      // Divisor 4 -> 2 mid-LOW: this LOW and next HIGH keep 4.
      runCycle("chg_low0", 10'd4, 6'b100001);
      runCycle("chg_low1", 10'd2, 6'b100001);
      runCycle("chg_low2", 10'd2, 6'b100001);
      runCycle("chg_low3", 10'd2, 6'b101001);
      highPhase("chg_high4", 4, 10'd2);
      lowPhase("div2_low", 2, 10'd2);
      highPhase("div2_high", 2, 10'd2);
      lowPhase("div2_low", 2, 10'd2);
      highPhase("div2_high_to3", 2, 10'd3);

      // Divisor 3, pause raised in 2nd HIGH cycle: HIGH completes, then idle.
      lowPhase("div3_low", 3, 10'd3);
      runCycle("pause_h1", 10'd3, 6'b110001);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd3);
      checkOutput("pause_h2", outs, 6'b110001);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd3);
      checkOutput("pause_h3_neg", outs, 6'b110101);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd3);
         checkOutput("paused_low", outs, 6'b100000);
      end
      lowPhase("resume_low", 3, 10'd3);
      highPhase("resume_high", 3, 10'd3);

      // Pause arriving on the LOW terminal count suppresses the rising strobe.
      runCycle("term_low0", 10'd3, 6'b100001);
      runCycle("term_low1", 10'd3, 6'b100001);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd3);
      checkOutput("term_pause", outs, 6'b100000);
      lowPhase("term_restart", 3, 10'd3);
      highPhase("div3_high_to5", 3, 10'd5);

      // Divisor 5, reset pulsed in the 3rd HIGH cycle.
      lowPhase("div5_low", 5, 10'd5);
      runCycle("div5_h1", 10'd5, 6'b110001);
      runCycle("div5_h2", 10'd5, 6'b110001);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 10'd5);
      checkOutput("rst_in_high", outs, 6'b110001);
      runCycle("post_rst_off", 10'd5, 6'b000000);
      runCycle("post_rst_l1", 10'd5, 6'b000001);
      runCycle("post_rst_l2", 10'd5, 6'b100001);
      runCycle("post_rst_l3", 10'd5, 6'b100001);
      runCycle("post_rst_l4", 10'd5, 6'b100001);
      runCycle("post_rst_l5_pos", 10'd5, 6'b101001);
      highPhase("div5_high_to0", 5, 10'd0);

      // Divide-by-1: strobes follow run 1,1,0,1; sd_clk stays low.
      runCycle("div1_run1", 10'd0, 6'b101111);
      runCycle("div1_run2", 10'd0, 6'b101111);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 10'd0);
      checkOutput("div1_pause", outs, 6'b100010);
      runCycle("div1_run4", 10'd0, 6'b101111);

      // SD enable drops, then internal enable drops.
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      checkOutput("sd_dis_low", outs, 6'b100010);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 10'd0);
      checkOutput("sd_dis_off", outs, 6'b100000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("ie_fall_c0", outs, 6'b100000);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("ie_fall_c1", outs, 6'b000000);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
